// File: rtl/display_scan_mux_if.sv
// Bundle of signals between the scan multiplexer and its host/display side.
// The host owns load/digits_in/blank_lz. The scanner drives the display outputs.
interface display_scan_mux_if #(
   parameter int DIGITS = 4
);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic                load;
   logic [4*DIGITS-1:0] digits_in;
   logic                blank_lz;
   logic                ready;
   logic [3:0]          bcd;
   logic [IDX_W-1:0]    digit_idx;
   logic [DIGITS-1:0]   anodes;

   modport master (
      output load, digits_in, blank_lz,
      input  ready, bcd, digit_idx, anodes
   );

   modport slave (
      input  load, digits_in, blank_lz,
      output ready, bcd, digit_idx, anodes
   );
endinterface

// File: rtl/display_scan_mux.sv
// Time-multiplexed common-anode 7-segment scanner with per-slot dead-time,
// a frame-synchronous display register and optional leading-zero blanking.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_DEAD | dead-time at the start of a digit slot, all anodes inactive
// ST_ON   | on-time, anode[digit_idx] active unless leading-zero blanked
module display_scan_mux #(
   parameter int DIGITS           = 4,
   parameter int REFRESH_DIV      = 50000,
   parameter int BLANK_CYCLES     = 16,
   parameter int ANODE_ACTIVE_LOW = 1
) (
   input logic               clk,
   input logic               rst_n,
   display_scan_mux_if.slave bus
);
   localparam int IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int ON_CYCLES = REFRESH_DIV - BLANK_CYCLES;

   localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(ON_CYCLES - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DIGITS - 1);

   typedef enum logic {ST_DEAD, ST_ON} state_t;

   state_t              state_q,   state_d;
   logic [CNT_W-1:0]    cnt_q,     cnt_d;
   logic [IDX_W-1:0]    idx_q,     idx_d;
   logic [4*DIGITS-1:0] disp_q,    disp_d;
   logic [4*DIGITS-1:0] shadow_q,  shadow_d;
   logic                pending_q, pending_d;
   logic                ready_q,   ready_d;

   logic                frame_end;
   logic [DIGITS-1:0]   lz_blank;
   logic                zero_run;
   logic                lit;
   logic [DIGITS-1:0]   anode_on;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + 1'b1;
      idx_d     = idx_q;
      disp_d    = disp_q;
      shadow_d  = shadow_q;
      pending_d = pending_q;
      ready_d   = ready_q;
      frame_end = 1'b0;

      case (state_q)
         ST_DEAD: begin
            if (cnt_q == DEAD_LAST) begin
               state_d = ST_ON;
               cnt_d   = '0;
            end
         end
         ST_ON: begin
            if (cnt_q == ON_LAST) begin
               state_d   = ST_DEAD;
               cnt_d     = '0;
               idx_d     = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
               frame_end = (idx_q == LAST_IDX);
            end
         end
         default: state_d = ST_DEAD;
      endcase

      // ready is only ever 1 while nothing is pending, so the transfer and the
      // capture below can never both fire on the same edge.
      if (frame_end && pending_q) begin
         disp_d    = shadow_q;
         pending_d = 1'b0;
         ready_d   = 1'b1;
      end
      if (bus.load && ready_q) begin
         shadow_d  = bus.digits_in;
         pending_d = 1'b1;
         ready_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_DEAD;
         cnt_q     <= '0;
         idx_q     <= '0;
         disp_q    <= '0;
         shadow_q  <= '0;
         pending_q <= 1'b0;
         ready_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         disp_q    <= disp_d;
         shadow_q  <= shadow_d;
         pending_q <= pending_d;
         ready_q   <= ready_d;
      end
   end

   // lz_blank[i] is set when digit i and all more-significant digits are zero.
   always_comb begin
      zero_run = 1'b1;
      lz_blank = '0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zero_run    = zero_run & (disp_q[4*i +: 4] == 4'd0);
         lz_blank[i] = zero_run;
      end
      lit      = (state_q == ST_ON) && !(bus.blank_lz && lz_blank[idx_q]);
      anode_on = lit ? (DIGITS'(1) << idx_q) : '0;
   end

   assign bus.anodes    = (ANODE_ACTIVE_LOW != 0) ? ~anode_on : anode_on;
   assign bus.bcd       = disp_q[4*int'(idx_q) +: 4];
   assign bus.digit_idx = idx_q;
   assign bus.ready     = ready_q;
endmodule

// File: tb/tb_display_scan_mux.sv
// Scoreboard bench for display_scan_mux: a cycle-count reference model queues the
// expected outputs of every cycle, and a negedge monitor compares them.
module tb_display_scan_mux;
   localparam int DIGITS = 4;
   localparam int RD     = 8;
   localparam int BLANK  = 2;
   localparam int FRAME  = DIGITS * RD;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   display_scan_mux_if #(.DIGITS(DIGITS)) bus ();

   display_scan_mux #(
      .DIGITS(DIGITS), .REFRESH_DIV(RD), .BLANK_CYCLES(BLANK), .ANODE_ACTIVE_LOW(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   typedef struct packed {
      logic [3:0] anodes;
      logic [3:0] bcd;
      logic [1:0] idx;
      logic       ready;
   } obs_t;

   obs_t sb[$];
   int total = 0;
   int bad   = 0;

   // Reference model: t is the cycle number since reset release.
   int          t;
   logic [15:0] m_disp, m_shadow;
   bit          m_pending, m_ready;

   task automatic model_reset();
      t = 0; m_disp = '0; m_shadow = '0; m_pending = 0; m_ready = 1;
   endtask

   function automatic obs_t model_out();
      obs_t        o;
      int          idx, pos;
      logic [15:0] upper;
      pos      = t % RD;
      idx      = (t / RD) % DIGITS;
      upper    = m_disp >> (4 * idx);
      o.bcd    = upper[3:0];
      o.idx    = idx[1:0];
      o.ready  = m_ready;
      o.anodes = 4'b1111;
      if (pos >= BLANK && !(bus.blank_lz && idx > 0 && upper == 16'd0))
         o.anodes[idx] = 1'b0;
      return o;
   endfunction

   initial begin
      model_reset();
      forever begin
         @(posedge clk);
         if (!rst_n) model_reset();
         else begin
            if (t % FRAME == FRAME - 1 && m_pending) begin
               m_disp = m_shadow; m_pending = 0; m_ready = 1;
            end else if (bus.load && m_ready) begin
               m_shadow = bus.digits_in; m_pending = 1; m_ready = 0;
            end
            t++;
         end
         #2;
         sb.push_back(model_out());
      end
   end

   initial begin
      obs_t exp_o, act_o;
      @(posedge clk);
      forever begin
         @(negedge clk);
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty t=%0d got nothing to compare, want an entry", t);
         end else begin
            exp_o = sb.pop_front();
            act_o = {bus.anodes, bus.bcd, bus.digit_idx, bus.ready};
            if (act_o !== exp_o) begin
               bad++;
               $display("FAIL scan t=%0d got an=%b bcd=%h idx=%0d rdy=%b want an=%b bcd=%h idx=%0d rdy=%b",
                        t, act_o.anodes, act_o.bcd, act_o.idx, act_o.ready,
                        exp_o.anodes, exp_o.bcd, exp_o.idx, exp_o.ready);
            end
         end
      end
   end

   task automatic check(string name, logic [15:0] got, logic [15:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got %h want %h", name, got, want);
      end
   endtask

   task automatic tick(int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic pulse_load(logic [15:0] v);
      bus.load = 1'b1; bus.digits_in = v;
      tick(1);
      bus.load = 1'b0;
   endtask

   task automatic wait_phase(int ph, int limit);
      int n = 0;
      while (t % FRAME != ph && n < limit) begin tick(1); n++; end
      total++;
      if (t % FRAME != ph) begin
         bad++;
         $display("FAIL wait_phase got phase %0d want %0d", t % FRAME, ph);
      end
   endtask

   task automatic wait_ready(int limit);
      int n = 0;
      while (!m_ready && n < limit) begin tick(1); n++; end
      total++;
      if (!m_ready) begin
         bad++;
         $display("FAIL wait_ready got ready=0 after %0d cycles want 1", limit);
      end
   endtask

   function automatic logic [15:0] rand_val();
      logic [15:0] v;
      v = 16'($urandom);
      return v >> (4 * $urandom_range(0, 4));
   endfunction

   initial begin
      bus.load = 1'b0; bus.digits_in = '0; bus.blank_lz = 1'b0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      check("rst_anodes", 16'(bus.anodes), 16'hF);
      check("rst_bcd",    16'(bus.bcd),    16'h0);
      check("rst_ready",  16'(bus.ready),  16'h1);
      check("rst_idx",    16'(bus.digit_idx), 16'h0);
      tick(3);
      @(negedge clk); #1 rst_n = 1'b1;
      tick(1);

      tick(64);

      wait_phase(10, 2 * FRAME);
      pulse_load(16'h1234);
      tick(2);
      pulse_load(16'h9999);
      tick(3);
      pulse_load(16'h9999);
      wait_ready(2 * FRAME);
      tick(FRAME);
      pulse_load(16'h0042);
      wait_ready(2 * FRAME);
      tick(FRAME);

      bus.blank_lz = 1'b1;
      pulse_load(16'h0050);
      wait_ready(2 * FRAME);
      tick(FRAME + 3);
      pulse_load(16'h0000);
      wait_ready(2 * FRAME);
      tick(FRAME + 3);

      repeat (1500) begin
         if ($urandom_range(0, 5) == 0) pulse_load(rand_val());
         else begin
            if ($urandom_range(0, 39) == 0) bus.blank_lz = ~bus.blank_lz;
            tick(1);
         end
      end

      bus.blank_lz = 1'b0;
      wait_ready(2 * FRAME);
      wait_phase(1, 2 * FRAME);
      pulse_load(16'h5678);
      wait_phase(20, FRAME);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_anodes", 16'(bus.anodes), 16'hF);
      check("midrst_ready",  16'(bus.ready),  16'h1);
      check("midrst_idx",    16'(bus.digit_idx), 16'h0);
      sb.delete();
      model_reset();
      sb.push_back(model_out());
      tick(2);
      @(negedge clk); #1 rst_n = 1'b1;
      tick(2 * FRAME + 5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
